// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC start-up sequencer: state codes,
// entry format and the fixed list of initialisation writes.
package rtc_pkg;

  // Sequencer states; the top keeps them as plain 2-bit codes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } rtc_state_e;

  // Number of initialisation writes and width of the entry index.
  localparam int N_INIT = 6;
  localparam int IDX_W  = 3;

  // One write to the RTC: register address and the value to store there.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_entry_t;

  // Writes are issued in this order, entry 0 first.
  localparam init_entry_t INIT_TABLE [N_INIT] = '{
    '{addr: 8'h02, data: 8'h10},
    '{addr: 8'h02, data: 8'h00},
    '{addr: 8'h10, data: 8'hD2},
    '{addr: 8'h21, data: 8'h00},
    '{addr: 8'h22, data: 8'h00},
    '{addr: 8'h23, data: 8'h00}
  };

endpackage

// File: rtl/rtc_init_rom.sv
// Combinational lookup of the address/data pair for one table entry.
// Kept apart from the FSM so the write list can change on its own.
module rtc_init_rom
  import rtc_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       addr,
  output logic [7:0]       data
);

  // Out-of-range indices read as zero rather than X.
  always_comb begin
    addr = '0;
    data = '0;
    if (int'(idx) < N_INIT) begin
      addr = INIT_TABLE[idx].addr;
      data = INIT_TABLE[idx].data;
    end
  end

endmodule

// File: rtl/rtc_init_sequencer.sv
// RTC start-up sequencer: on a start level it walks the init table,
// issuing one req/ack write per entry with a low gap cycle between
// writes, aborts on an ack timeout, and raises listo until start drops.
module rtc_init_sequencer
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arranque,
  input  logic             ack,
  output logic             req,
  output logic             wr_en,
  output logic [7:0]       addr,
  output logic [7:0]       data,
  output logic             listo,
  output logic             busy,
  output logic             error,
  output logic [IDX_W-1:0] idx
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_FIN   = FIN;

  // Counter value seen on the last cycle a write may wait for ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INIT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             req_q, req_d;
  logic             listo_q, listo_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  // Entry about to be presented on the bus, looked up from the next index.
  logic             load_entry;
  logic [7:0]       rom_addr;
  logic [7:0]       rom_data;

  rtc_init_rom u_rom (
    .idx  (idx_d),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Next-state logic for the FSM, timeout counter and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    req_d      = req_q;
    listo_d    = listo_q;
    error_d    = error_q;
    load_entry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arranque) begin
          state_d    = S_ISSUE;
          idx_d      = '0;
          cnt_d      = '0;
          error_d    = 1'b0;
          req_d      = 1'b1;
          load_entry = 1'b1;
        end
      end

      S_ISSUE: begin
        // ack is checked first so a late ack on the last allowed cycle wins.
        if (ack) begin
          req_d   = 1'b0;
          state_d = S_GAP;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          error_d = 1'b1;
          listo_d = 1'b1;
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          listo_d = 1'b1;
          state_d = S_FIN;
        end else begin
          idx_d      = idx_q + 1'b1;
          req_d      = 1'b1;
          load_entry = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_FIN: begin
        // Stay done while the start register is still set, so it cannot retrigger.
        if (!arranque) begin
          listo_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        listo_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Address/data only change when a new entry is put on the bus.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (load_entry) begin
      addr_d = rom_addr;
      data_d = rom_data;
    end
  end

  // State and output registers; reset abandons any write in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      listo_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      listo_q <= listo_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign req   = req_q;
  assign wr_en = req_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign listo = listo_q;
  assign busy  = busy_q;
  assign error = error_q;
  assign idx   = idx_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Self-checking bench for rtc_init_sequencer: a write-level model of the
// start-up sequence is compared with every DUT output on each falling edge,
// with directed scenarios plus randomized ack latencies and start levels.
module tb_rtc_init_sequencer;

  localparam int TO = 8;   // ack timeout used for this instance

  logic       clk;
  logic       rst;
  logic       arranque;
  logic       ack;
  logic       req;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] data;
  logic       listo;
  logic       busy;
  logic       error;
  logic [2:0] idx;

  rtc_init_sequencer #(
    .TIMEOUT_CYC (TO),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arranque (arranque),
    .ack      (ack),
    .req      (req),
    .wr_en    (wr_en),
    .addr     (addr),
    .data     (data),
    .listo    (listo),
    .busy     (busy),
    .error    (error),
    .idx      (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected write list, written out independently of the design package.
  logic [7:0] tb_addr [6] = '{8'h02, 8'h02, 8'h10, 8'h21, 8'h22, 8'h23};
  logic [7:0] tb_data [6] = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Write-level model: one outstanding write, a pending gap, or done.
  bit m_out, m_gap, m_done, m_err, m_started;
  int m_entry, m_waited;

  // Stimulus knobs: per-entry ack latency (0 = never) and stray acks.
  int lat [6];
  bit spurious;

  // Observations of the DUT used by the directed literal checks.
  int rises, req_run, last_run;
  logic prev_req;
  logic [7:0] cap_addr [6];
  logic [7:0] cap_data [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_gap = 0; m_done = 0; m_err = 0; m_started = 0;
    m_entry = 0; m_waited = 0;
  endtask

  // One clock edge of the sequence rules, using the inputs sampled at it.
  task automatic model_step();
    if (m_out) begin
      m_waited++;
      if (ack) begin
        m_out = 0; m_gap = 1;
      end else if (m_waited == TO) begin
        m_out = 0; m_err = 1; m_done = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (m_entry == 5) m_done = 1;
      else begin
        m_entry++; m_out = 1; m_waited = 0;
      end
    end else if (m_done) begin
      if (!arranque) m_done = 0;
    end else if (arranque) begin
      m_out = 1; m_entry = 0; m_err = 0; m_waited = 0; m_started = 1;
    end
  endtask

  task automatic compare_all();
    check("req",   {31'b0, req},   {31'b0, m_out});
    check("wr_en", {31'b0, wr_en}, {31'b0, m_out});
    check("listo", {31'b0, listo}, {31'b0, m_done});
    check("busy",  {31'b0, busy},  {31'b0, m_out | m_gap | m_done});
    check("error", {31'b0, error}, {31'b0, m_err});
    check("idx",   {29'b0, idx},   32'(m_entry));
    check("addr",  {24'b0, addr},  m_started ? {24'b0, tb_addr[m_entry]} : 32'h0);
    check("data",  {24'b0, data},  m_started ? {24'b0, tb_data[m_entry]} : 32'h0);
  endtask

  // One cycle: step the model at the rising edge, compare on the falling
  // edge, then decide the ack to present at the next rising edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
    if (req === 1'b1) begin
      if (prev_req !== 1'b1) begin
        if (rises < 6) begin
          cap_addr[rises] = addr;
          cap_data[rises] = data;
        end
        rises++;
        $display("write cyc=%0d idx=%0d addr=%02h data=%02h", cyc, idx, addr, data);
        req_run = 0;
      end
      req_run++;
    end else if (prev_req === 1'b1) begin
      last_run = req_run;
    end
    prev_req = req;
    if (m_out) ack = (lat[m_entry] != 0) && (m_waited + 1 == lat[m_entry]);
    else ack = spurious && ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_lat(input int l);
    for (int i = 0; i < 6; i++) lat[i] = l;
  endtask

  // Runs until listo rises; n is the number of edges taken.
  task automatic run_until_listo(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (listo !== 1'b1 && n < maxc);
    check("listo_reached", {31'b0, listo}, 32'h1);
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy !== 1'b0 && n < maxc);
    check("idle_reached", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b0; arranque = 1'b0; ack = 1'b0; spurious = 1'b0;
    prev_req = 1'b0; rises = 0; req_run = 0; last_run = 0;
    set_lat(1);
    model_reset();
    #2;
    compare_all();
    check("reset_addr", {24'b0, addr}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    // Normal run: ack three cycles after every req rise.
    set_lat(3); rises = 0;
    arranque = 1'b1;
    run_until_listo(200, n);
    check("normal_cycles", n, 32'd25);
    check("normal_writes", rises, 32'd6);
    check("normal_addr2", {24'b0, cap_addr[2]}, 32'h10);
    check("normal_data2", {24'b0, cap_data[2]}, 32'hD2);
    check("normal_addr5", {24'b0, cap_addr[5]}, 32'h23);
    check("normal_error", {31'b0, error}, 32'h0);
    check("normal_reqlen", last_run, 32'd3);

    // Start held high after completion: listo stays up, nothing reissued.
    rises = 0;
    for (int i = 0; i < 20; i++) tick();
    check("held_listo", {31'b0, listo}, 32'h1);
    check("held_no_req", rises, 32'd0);
    arranque = 1'b0;
    tick();
    check("held_release_busy", {31'b0, busy}, 32'h0);
    tick(); tick();

    // Immediate ack on every entry.
    set_lat(1); rises = 0;
    arranque = 1'b1;
    run_until_listo(200, n);
    check("imm_cycles", n, 32'd13);
    arranque = 1'b0;
    run_until_idle(10);

    // Timeout on entry 2.
    lat = '{2, 1, 0, 3, 3, 3};
    arranque = 1'b1;
    run_until_listo(200, n);
    check("to_error", {31'b0, error}, 32'h1);
    check("to_idx", {29'b0, idx}, 32'd2);
    check("to_reqlen", last_run, 32'd8);
    arranque = 1'b0;
    tick();
    check("to_sticky", {31'b0, error}, 32'h1);
    set_lat(2);
    arranque = 1'b1;
    tick();
    check("to_restart_clear", {31'b0, error}, 32'h0);
    run_until_listo(200, n);
    arranque = 1'b0;
    run_until_idle(10);

    // Reset mid-sequence, asserted between clock edges.
    set_lat(4);
    arranque = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(m_entry == 3 && m_out) && n < 200);
    @(posedge clk);
    cyc++;
    model_step();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_listo", {31'b0, listo}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_idx", {29'b0, idx}, 32'd0);
    @(negedge clk);
    compare_all();
    rst = 1'b1; ack = 1'b0; prev_req = req;
    tick();
    check("rst_restart_idx", {29'b0, idx}, 32'd0);
    check("rst_restart_addr", {24'b0, addr}, 32'h02);
    check("rst_restart_req", {31'b0, req}, 32'h1);
    run_until_listo(200, n);
    arranque = 1'b0;
    run_until_idle(10);

    // Start dropped during entry 1: sequence completes, listo pulses once.
    set_lat(2); rises = 0;
    arranque = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(m_entry == 1 && m_out) && n < 200);
    arranque = 1'b0;
    run_until_listo(200, n);
    n = 0;
    do begin tick(); n++; end while (listo === 1'b1 && n < 50);
    check("drop_listo_len", n, 32'd1);
    check("drop_writes", rises, 32'd6);
    check("drop_idle", {31'b0, busy}, 32'h0);

    // Randomized sequences: latencies around the timeout, stray acks,
    // and start levels that drop at arbitrary points.
    spurious = 1'b1;
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 6; i++) lat[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
      arranque = 1'b1;
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) tick();
      arranque = 1'b0;
      run_until_idle(200);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) tick();
    end
    spurious = 1'b0;
    ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
